// File: rtl/eq_pkg.sv
// Shared types and constants for the slide-pot scheduler.
package eq_pkg;

  localparam int unsigned NUM_POTS = 6;
  localparam int unsigned POT_W    = 12;
  localparam int unsigned CHNL_W   = 3;
  localparam int unsigned IDX_W    = 3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    STORE,
    ADV,
    GAP
  } pot_state_t;

  typedef logic [IDX_W-1:0] pot_idx_t;

  // A2D channel wired to each slot: LP, B1, B2, B3, HP, volume
  localparam logic [CHNL_W-1:0] POT_CHNL [NUM_POTS] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};

  // Slot index to A2D channel; out-of-range indices fall back to slot 0
  function automatic logic [CHNL_W-1:0] chnl_of(input pot_idx_t idx);
    logic [CHNL_W-1:0] c;
    c = POT_CHNL[0];
    for (int unsigned i = 0; i < NUM_POTS; i++) begin
      if (idx == pot_idx_t'(i)) c = POT_CHNL[i];
    end
    return c;
  endfunction

endpackage

// File: rtl/slide_pot_sched_pot_iir.sv
// Two-tap averaging stage for pot samples: (prev + sample + 1) >> 1.
// Present only when POT_FILT_EN is defined.
`ifdef POT_FILT_EN
module pot_iir
  import eq_pkg::*;
(
  input  logic [POT_W-1:0] prev,
  input  logic [POT_W-1:0] sample,
  input  logic             bypass,
  output logic [POT_W-1:0] avg_c
);

  logic [POT_W:0] sum;

  // Round-half-up average in a 13-bit intermediate; bypass loads the raw sample
  always_comb begin
    sum   = (POT_W+1)'(prev) + (POT_W+1)'(sample) + (POT_W+1)'(1);
    avg_c = bypass ? sample : sum[POT_W:1];
  end

endmodule
`endif

// File: rtl/slide_pot_sched.sv
// Round-robin scheduler that samples the six equalizer slide-pots through
// the A2D SPI master and holds the latest result of each in a register.
// Optional feature macro: POT_FILT_EN (averaging filter on each store).
module slide_pot_sched
  import eq_pkg::*;
#(
  parameter int unsigned GAP_CYC = 1024,
  parameter int unsigned TMO_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              strt_cnv,
  output logic [CHNL_W-1:0] chnnl,
  input  logic              cnv_cmplt,
  input  logic [POT_W-1:0]  res,
  output logic [POT_W-1:0]  LP_pot,
  output logic [POT_W-1:0]  B1_pot,
  output logic [POT_W-1:0]  B2_pot,
  output logic [POT_W-1:0]  B3_pot,
  output logic [POT_W-1:0]  HP_pot,
  output logic [POT_W-1:0]  volume,
  output logic              pots_vld,
  output logic              sweep_done,
  output logic              a2d_err
);

  localparam int unsigned CNT_MAX_CYC = (GAP_CYC > TMO_CYC) ? GAP_CYC : TMO_CYC;
  localparam int unsigned CNT_W       = $clog2(CNT_MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TMO_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
  localparam pot_idx_t         LAST_SLOT = pot_idx_t'(NUM_POTS - 1);

  pot_state_t        state_q, state_d;
  pot_idx_t          idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic [POT_W-1:0]  res_q, res_d;
  logic [POT_W-1:0]  pot_q [NUM_POTS];
  logic [POT_W-1:0]  pot_d [NUM_POTS];
  logic              strt_cnv_q, strt_cnv_d;
  logic [CHNL_W-1:0] chnnl_q, chnnl_d;
  logic              sweep_done_q, sweep_done_d;
  logic              pots_vld_q, pots_vld_d;
  logic              a2d_err_q, a2d_err_d;
  logic              sweep_err_q, sweep_err_d;
  logic [POT_W-1:0]  store_val;

`ifdef POT_FILT_EN
  logic              first_sweep_q, first_sweep_d;
  logic [POT_W-1:0]  cur_pot;

  // Current slot's held value feeds the averaging stage
  always_comb begin
    cur_pot = pot_q[0];
    for (int unsigned i = 0; i < NUM_POTS; i++) begin
      if (idx_q == pot_idx_t'(i)) cur_pot = pot_q[i];
    end
  end

  pot_iir u_pot_iir (
    .prev   (cur_pot),
    .sample (res_q),
    .bypass (first_sweep_q),
    .avg_c  (store_val)
  );
`else
  assign store_val = res_q;
`endif

  // Saturating increment shared by the gap and timeout counts
  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    res_d        = res_q;
    pot_d        = pot_q;
    strt_cnv_d   = 1'b0;
    sweep_done_d = 1'b0;
    pots_vld_d   = pots_vld_q;
    a2d_err_d    = a2d_err_q;
    sweep_err_d  = sweep_err_q;
`ifdef POT_FILT_EN
    first_sweep_d = first_sweep_q;
`endif

    case (state_q)
      IDLE: begin
        if (en) state_d = START;
      end

      START: begin
        cnt_d   = '0;
        state_d = WAIT;
        if (idx_q == '0) sweep_err_d = 1'b0;
      end

      // A completion on the final timeout cycle still counts as a result
      WAIT: begin
        if (cnv_cmplt) begin
          res_d   = res;
          state_d = STORE;
        end else if (cnt_q >= TMO_LAST) begin
          a2d_err_d   = 1'b1;
          sweep_err_d = 1'b1;
          state_d     = ADV;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      STORE: begin
        for (int unsigned i = 0; i < NUM_POTS; i++) begin
          if (idx_q == pot_idx_t'(i)) pot_d[i] = store_val;
        end
        state_d = ADV;
      end

      ADV: begin
        if (idx_q == LAST_SLOT) begin
          idx_d        = '0;
          cnt_d        = '0;
          sweep_done_d = 1'b1;
          if (!sweep_err_q) pots_vld_d = 1'b1;
`ifdef POT_FILT_EN
          first_sweep_d = 1'b0;
`endif
          state_d = GAP;
        end else begin
          idx_d   = idx_q + pot_idx_t'(1);
          state_d = en ? START : IDLE;
        end
      end

      GAP: begin
        if (!en) begin
          state_d = IDLE;
        end else if (cnt_q >= GAP_LAST) begin
          state_d = START;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: state_d = IDLE;
    endcase

    strt_cnv_d = (state_d == START);
    chnnl_d    = chnl_of(idx_d);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      res_q        <= '0;
      for (int unsigned i = 0; i < NUM_POTS; i++) pot_q[i] <= '0;
      strt_cnv_q   <= 1'b0;
      chnnl_q      <= POT_CHNL[0];
      sweep_done_q <= 1'b0;
      pots_vld_q   <= 1'b0;
      a2d_err_q    <= 1'b0;
      sweep_err_q  <= 1'b0;
`ifdef POT_FILT_EN
      first_sweep_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      res_q        <= res_d;
      pot_q        <= pot_d;
      strt_cnv_q   <= strt_cnv_d;
      chnnl_q      <= chnnl_d;
      sweep_done_q <= sweep_done_d;
      pots_vld_q   <= pots_vld_d;
      a2d_err_q    <= a2d_err_d;
      sweep_err_q  <= sweep_err_d;
`ifdef POT_FILT_EN
      first_sweep_q <= first_sweep_d;
`endif
    end
  end

  assign strt_cnv   = strt_cnv_q;
  assign chnnl      = chnnl_q;
  assign sweep_done = sweep_done_q;
  assign pots_vld   = pots_vld_q;
  assign a2d_err    = a2d_err_q;
  assign LP_pot     = pot_q[0];
  assign B1_pot     = pot_q[1];
  assign B2_pot     = pot_q[2];
  assign B3_pot     = pot_q[3];
  assign HP_pot     = pot_q[4];
  assign volume     = pot_q[5];

endmodule

// File: tb/tb_slide_pot_sched.sv
// Self-checking bench for slide_pot_sched: A2D responder with a slot-level
// reference model, plus channel and end-of-sweep scoreboard monitors.
module tb_slide_pot_sched;

  localparam int unsigned GAP   = 16;
  localparam int unsigned TMO   = 64;
  localparam int          N_SWP = 14;
  localparam logic [2:0]  CHNL_MAP [6] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};

  typedef struct packed {
    logic [71:0] pots;
    logic        vld;
    logic        err;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst, en, strt_cnv, cnv_cmplt;
  logic [2:0]  chnnl;
  logic [11:0] res;
  logic [11:0] LP_pot, B1_pot, B2_pot, B3_pot, HP_pot, volume;
  logic        pots_vld, sweep_done, a2d_err;

  always #5 clk = ~clk;

  slide_pot_sched #(.GAP_CYC(GAP), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .en(en), .strt_cnv(strt_cnv), .chnnl(chnnl),
    .cnv_cmplt(cnv_cmplt), .res(res),
    .LP_pot(LP_pot), .B1_pot(B1_pot), .B2_pot(B2_pot), .B3_pot(B3_pot),
    .HP_pot(HP_pot), .volume(volume),
    .pots_vld(pots_vld), .sweep_done(sweep_done), .a2d_err(a2d_err)
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic [2:0]  exp_chnl_q [$];
  snap_t       exp_snap_q [$];
  logic [11:0] ref_pot [6];
  bit          ref_vld, ref_err, sweep_err_m, first_m;
  int          slot_m, sw, sw_since_rst;
  bit          rst_done;
  logic        strt_prev;
  logic [2:0]  exp_c;
  snap_t       exp_s;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] dut_pot(input int i);
    case (i)
      0:       return LP_pot;
      1:       return B1_pot;
      2:       return B2_pot;
      3:       return B3_pot;
      4:       return HP_pot;
      default: return volume;
    endcase
  endfunction

  function automatic logic [71:0] dut_pots();
    return {volume, HP_pot, B3_pot, B2_pot, B1_pot, LP_pot};
  endfunction

  function automatic logic [71:0] ref_pots();
    logic [71:0] p;
    for (int i = 0; i < 6; i++) p[i*12 +: 12] = ref_pot[i];
    return p;
  endfunction

  function automatic logic [11:0] model_store(input logic [11:0] old, input logic [11:0] r);
`ifdef POT_FILT_EN
    if (first_m) return r;
    return 12'((13'(old) + 13'(r) + 13'd1) >> 1);
`else
    return r;
`endif
  endfunction

  // Slot outcome: update pots/flags, predict next channel and sweep snapshot
  task automatic model_finish(input bit stored, input logic [11:0] r);
    snap_t s;
    if (stored) ref_pot[slot_m] = model_store(ref_pot[slot_m], r);
    else begin
      ref_err     = 1'b1;
      sweep_err_m = 1'b1;
    end
    if (slot_m == 5) begin
      if (!sweep_err_m) ref_vld = 1'b1;
      s.pots = ref_pots();
      s.vld  = ref_vld;
      s.err  = ref_err;
      exp_snap_q.push_back(s);
      sweep_err_m = 1'b0;
      first_m     = 1'b0;
      slot_m      = 0;
      sw++;
      sw_since_rst++;
    end else begin
      slot_m++;
    end
    exp_chnl_q.push_back(CHNL_MAP[slot_m]);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) ref_pot[i] = 12'h000;
    ref_vld = 0; ref_err = 0; sweep_err_m = 0; first_m = 1;
    slot_m = 0; sw_since_rst = 0;
    exp_chnl_q.delete();
    exp_snap_q.delete();
    exp_chnl_q.push_back(CHNL_MAP[0]);
  endtask

  task automatic wait_strt(output bit ok);
    ok = 0;
    for (int i = 0; i < int'(GAP + TMO) + 50 && !ok; i++) begin
      if (strt_cnv === 1'b1) ok = 1;
      else @(negedge clk);
    end
  endtask

  task automatic quiet_window(input string name, input int cyc);
    bit seen;
    seen = 0;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      if (strt_cnv === 1'b1) seen = 1;
    end
    chk(name, 72'(seen), 72'(0));
  endtask

  // Channel monitor: every start pulse must carry the predicted channel
  always @(negedge clk) begin
    if (rst === 1'b0 && strt_cnv === 1'b1) begin
      chk("strt_width", 72'(strt_prev), 72'(0));
      if (exp_chnl_q.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL chnnl_unexpected: got strt_cnv with chnnl %0d, required no start", chnnl);
      end else begin
        exp_c = exp_chnl_q.pop_front();
        chk("chnnl", 72'(chnnl), 72'(exp_c));
      end
    end
    strt_prev <= strt_cnv;
  end

  // Sweep monitor: pot bank and flags at each sweep_done pulse
  always @(negedge clk) begin
    if (rst === 1'b0 && sweep_done === 1'b1) begin
      if (exp_snap_q.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL sweep_unexpected: got sweep_done, required none");
      end else begin
        exp_s = exp_snap_q.pop_front();
        chk("sweep_pots", dut_pots(), exp_s.pots);
        chk("sweep_vld", 72'(pots_vld), 72'(exp_s.vld));
        chk("sweep_err", 72'(a2d_err), 72'(exp_s.err));
      end
    end
  end

  initial begin
    #600000;
    n_miss++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1);
  end

  initial begin
    bit          ok, drop_wait, drop_gap, do_rst, spur;
    int          s, k, m, mode;
    logic [11:0] r, old;

    rst = 1; en = 0; cnv_cmplt = 0; res = 0;
    sw = 0; rst_done = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_pots", dut_pots(), 72'(0));
    chk("rst_strt", 72'(strt_cnv), 72'(0));
    chk("rst_chnnl", 72'(chnnl), 72'(1));
    chk("rst_vld", 72'(pots_vld), 72'(0));
    chk("rst_err", 72'(a2d_err), 72'(0));
    chk("rst_sweep_done", 72'(sweep_done), 72'(0));
    rst = 0;
    @(negedge clk);
    chk("idle_no_strt", 72'(strt_cnv), 72'(0));
    en = 1;
    @(negedge clk);
    chk("first_strt", 72'(strt_cnv), 72'(1));

    while (sw < N_SWP) begin
      wait_strt(ok);
      if (!ok) begin
        n_vec++; n_miss++;
        $display("FAIL strt_timeout: got no strt_cnv within budget, required a pulse");
        break;
      end
      s = slot_m;
      mode = 0; k = $urandom_range(1, 20); r = 12'($urandom);
      drop_wait = 0; drop_gap = 0; do_rst = 0; spur = 0;
      if (sw == 0) begin
        r = 12'h800; k = $urandom_range(1, 10);
      end else if (sw == 1 && s == 2) begin
        mode = 2; r = 12'hABC;
      end else if (sw == 2 && s == 3) begin
        mode = 1;
      end else if (sw == 3 && s == 1) begin
        drop_wait = 1;
      end else if (sw == 5 && s == 5) begin
        drop_gap = 1;
      end else if (sw == 7 && s == 2 && !rst_done) begin
        do_rst = 1;
      end else if (rst_done && sw_since_rst == 0 && s == 3) begin
        mode = 1;
      end else if (sw >= 4) begin
        m = $urandom_range(0, 99);
        if (m < 6) mode = 1;
        else if (m < 12) mode = 2;
        spur = ($urandom_range(0, 4) == 0);
      end

      if (do_rst) begin
        repeat (3) @(negedge clk);
        rst = 1; en = 0;
        @(negedge clk);
        chk("mrst_pots", dut_pots(), 72'(0));
        chk("mrst_strt", 72'(strt_cnv), 72'(0));
        chk("mrst_chnnl", 72'(chnnl), 72'(1));
        chk("mrst_vld", 72'(pots_vld), 72'(0));
        chk("mrst_err", 72'(a2d_err), 72'(0));
        rst = 0;
        model_reset();
        rst_done = 1;
        @(negedge clk);
        chk("mrst_idle", 72'(strt_cnv), 72'(0));
        en = 1;
        @(negedge clk);
        chk("mrst_first_strt", 72'(strt_cnv), 72'(1));
        continue;
      end

      if (drop_wait) en = 0;
      if (spur) begin
        cnv_cmplt = 1; res = 12'($urandom);
      end

      if (mode == 1) begin
        for (int i = 0; i < int'(TMO); i++) begin
          @(negedge clk);
          if (i == 0) cnv_cmplt = 0;
        end
        old = ref_pot[s];
        model_finish(0, 12'h000);
        @(negedge clk);
        chk("tmo_err", 72'(a2d_err), 72'(1));
        chk("tmo_pot_kept", 72'(dut_pot(s)), 72'(old));
        if (s != 5) begin
          @(negedge clk);
          chk("tmo_next_strt", 72'(strt_cnv), 72'(1));
        end
      end else begin
        if (mode == 2) k = TMO;
        for (int i = 0; i < k; i++) begin
          @(negedge clk);
          if (i == 0) cnv_cmplt = 0;
        end
        cnv_cmplt = 1; res = r;
        old = ref_pot[s];
        model_finish(1, r);
        @(negedge clk);
        cnv_cmplt = 0; res = 12'($urandom);
        chk("pot_n1_old", 72'(dut_pot(s)), 72'(old));
        @(negedge clk);
        chk("pot_n2_new", 72'(dut_pot(s)), 72'(ref_pot[s]));
        chk("err_flag", 72'(a2d_err), 72'(ref_err));
        if (drop_wait) begin
          quiet_window("idle_quiet", 5000);
          en = 1;
          @(negedge clk);
          chk("resume_strt", 72'(strt_cnv), 72'(1));
        end else if (drop_gap) begin
          en = 0;
          quiet_window("gap_idle_quiet", 40);
          en = 1;
          @(negedge clk);
          chk("gap_resume_strt", 72'(strt_cnv), 72'(1));
        end else if (s != 5) begin
          @(negedge clk);
          chk("next_strt_n3", 72'(strt_cnv), 72'(1));
        end
      end
    end

    repeat (6) @(negedge clk);
    chk("snap_drained", 72'(exp_snap_q.size()), 72'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
